// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions used by the SEQ pipeline stages
// (fetch, decode/write-back, execute, memory).
//   - icode encodings I_HALT .. I_POPQ
//   - register ids R_RSP and R_NONE
//   - default datapath width
package y86_pkg;

    localparam int WIDTH_DEF = 64;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_RSP  = 4'h4;
    localparam logic [3:0] R_NONE = 4'hF;

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 program register file: 15 x WIDTH registers.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   wb_en                 global write enable
//   dst_e/val_e           write port E
//   dst_m/val_m           write port M (wins over E on the same id)
//   src_a/src_b -> val_a/val_b   combinational read ports
//   dbg_id -> dbg_val     combinational debug read port
// Id R_NONE disables a write port and reads as zero.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int               WIDTH    = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RSP_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_en,
    input  logic [3:0]       dst_e,
    input  logic [WIDTH-1:0] val_e,
    input  logic [3:0]       dst_m,
    input  logic [WIDTH-1:0] val_m,
    input  logic [3:0]       src_a,
    input  logic [3:0]       src_b,
    output logic [WIDTH-1:0] val_a,
    output logic [WIDTH-1:0] val_b,
    input  logic [3:0]       dbg_id,
    output logic [WIDTH-1:0] dbg_val
);

    logic [WIDTH-1:0] regs_q [15];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= (i == int'(R_RSP)) ? RSP_INIT : '0;
            end
        end else if (wb_en) begin
            if (dst_e != R_NONE) begin
                regs_q[dst_e] <= val_e;
            end
            // Later assignment wins, so port M overrides E (popq %rsp).
            if (dst_m != R_NONE) begin
                regs_q[dst_m] <= val_m;
            end
        end
    end

    assign val_a   = (src_a  == R_NONE) ? '0 : regs_q[src_a];
    assign val_b   = (src_b  == R_NONE) ? '0 : regs_q[src_b];
    assign dbg_val = (dbg_id == R_NONE) ? '0 : regs_q[dbg_id];

endmodule

// File: rtl/decode_writeback.sv
// SEQ Y86-64 combined Decode and Write-back stage.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   icode, rA, rB, cnd  instruction fields from Fetch, condition from Execute
//   valE, valM, wb_en   write-back data and enable
//   valA, valB          register reads to Execute
//   srcA/srcB/dstE/dstM decoded register ids
//   dbg_id -> dbg_val   debug register read
// Decode is purely combinational; the only state is the register file.
module decode_writeback
    import y86_pkg::*;
#(
    parameter int               WIDTH    = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RSP_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             cnd,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valM,
    input  logic             wb_en,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    output logic [3:0]       srcA,
    output logic [3:0]       srcB,
    output logic [3:0]       dstE,
    output logic [3:0]       dstM,
    input  logic [3:0]       dbg_id,
    output logic [WIDTH-1:0] dbg_val
);

    logic [3:0] src_a, src_b, dst_e, dst_m;

    always_comb begin
        src_a = R_NONE;
        src_b = R_NONE;
        dst_e = R_NONE;
        dst_m = R_NONE;
        case (icode)
            I_CMOVXX: begin
                src_a = rA;
                dst_e = cnd ? rB : R_NONE;
            end
            I_IRMOVQ: begin
                dst_e = rB;
            end
            I_RMMOVQ: begin
                src_a = rA;
                src_b = rB;
            end
            I_MRMOVQ: begin
                src_b = rB;
                dst_m = rA;
            end
            I_OPQ: begin
                src_a = rA;
                src_b = rB;
                dst_e = rB;
            end
            I_CALL: begin
                src_b = R_RSP;
                dst_e = R_RSP;
            end
            I_RET: begin
                src_a = R_RSP;
                src_b = R_RSP;
                dst_e = R_RSP;
            end
            I_PUSHQ: begin
                src_a = rA;
                src_b = R_RSP;
                dst_e = R_RSP;
            end
            I_POPQ: begin
                src_a = R_RSP;
                src_b = R_RSP;
                dst_e = R_RSP;
                dst_m = rA;
            end
            default: begin
            end
        endcase
    end

    assign srcA = src_a;
    assign srcB = src_b;
    assign dstE = dst_e;
    assign dstM = dst_m;

    y86_regfile #(
        .WIDTH    (WIDTH),
        .RSP_INIT (RSP_INIT)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wb_en   (wb_en),
        .dst_e   (dst_e),
        .val_e   (valE),
        .dst_m   (dst_m),
        .val_m   (valM),
        .src_a   (src_a),
        .src_b   (src_b),
        .val_a   (valA),
        .val_b   (valB),
        .dbg_id  (dbg_id),
        .dbg_val (dbg_val)
    );

endmodule

// File: tb/tb_decode_writeback.sv
module tb_decode_writeback;

    localparam logic [63:0] RSP_INIT = 64'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  icode = 4'h1;
    logic [3:0]  rA = 4'hF;
    logic [3:0]  rB = 4'hF;
    logic        cnd = 1'b0;
    logic [63:0] valE = '0;
    logic [63:0] valM = '0;
    logic        wb_en = 1'b0;
    logic [63:0] valA, valB, dbg_val;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [3:0]  dbg_id = 4'hF;

    decode_writeback #(.WIDTH(64), .RSP_INIT(RSP_INIT)) dut (
        .clk(clk), .rst(rst), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
        .valE(valE), .valM(valM), .wb_en(wb_en),
        .valA(valA), .valB(valB), .srcA(srcA), .srcB(srcB),
        .dstE(dstE), .dstM(dstM), .dbg_id(dbg_id), .dbg_val(dbg_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp_v);
    endtask

    task automatic expect_v(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare against an observed value.
    task automatic compare_next(input logic [63:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty: got %h, want queued entry", obs);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_dbg(input logic [3:0] id, input logic [63:0] exp_v, input string tag);
        dbg_id = id;
        expect_v(tag, exp_v);
        #1;
        compare_next(dbg_val);
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic [63:0] e, input logic [63:0] m,
                         input logic en);
        icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m; wb_en = en;
    endtask

    task automatic expect_ids(input string tag, input logic [3:0] sa, input logic [3:0] sb,
                              input logic [3:0] de, input logic [3:0] dm);
        expect_v({tag, "_srcA"}, {60'd0, sa});
        expect_v({tag, "_srcB"}, {60'd0, sb});
        expect_v({tag, "_dstE"}, {60'd0, de});
        expect_v({tag, "_dstM"}, {60'd0, dm});
        #1;
        compare_next({60'd0, srcA});
        compare_next({60'd0, srcB});
        compare_next({60'd0, dstE});
        compare_next({60'd0, dstM});
    endtask

    initial begin
        // Reset contents
        #1 rst = 1'b1;
        #2;
        for (int i = 0; i < 16; i++) begin
            read_dbg(4'(i), (i == 4) ? RSP_INIT : 64'd0, $sformatf("rst_reg%0d", i));
        end
        @(negedge clk);
        rst = 1'b0;
        tick();

        // IRMOVQ rB=2
        drive(4'h3, 4'hF, 4'h2, 1'b0, 64'd1234, 64'd0, 1'b1);
        expect_ids("irmovq", 4'hF, 4'hF, 4'h2, 4'hF);
        read_dbg(4'h2, 64'd0, "irmovq_no_bypass");
        tick();
        drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1);
        read_dbg(4'h2, 64'd1234, "irmovq_reg2");

        // OPQ read-back, no write
        drive(4'h6, 4'h2, 4'h2, 1'b0, 64'd0, 64'd0, 1'b0);
        expect_v("opq_valA", 64'd1234);
        expect_v("opq_valB", 64'd1234);
        #1;
        compare_next(valA);
        compare_next(valB);
        tick();

        // CMOVXX, condition false then true
        drive(4'h2, 4'h2, 4'h3, 1'b0, 64'd1234, 64'd0, 1'b1);
        expect_ids("cmov_nc", 4'h2, 4'hF, 4'hF, 4'hF);
        tick();
        drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1);
        read_dbg(4'h3, 64'd0, "cmov_nc_reg3");
        drive(4'h2, 4'h2, 4'h3, 1'b1, 64'd1234, 64'd0, 1'b1);
        expect_ids("cmov_c", 4'h2, 4'hF, 4'h3, 4'hF);
        tick();
        drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1);
        read_dbg(4'h3, 64'd1234, "cmov_c_reg3");

        // POPQ %rsp: M port wins
        drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hABC, 1'b1);
        expect_ids("popq", 4'h4, 4'h4, 4'h4, 4'h4);
        expect_v("popq_valA", RSP_INIT);
        expect_v("popq_valB", RSP_INIT);
        #1;
        compare_next(valA);
        compare_next(valB);
        tick();
        drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1);
        read_dbg(4'h4, 64'hABC, "popq_reg4");

        // MRMOVQ with write-back stalled, then enabled
        drive(4'h5, 4'h5, 4'h2, 1'b0, 64'd0, 64'd77, 1'b0);
        expect_ids("mrmovq", 4'hF, 4'h2, 4'hF, 4'h5);
        expect_v("mrmovq_valB", 64'd1234);
        #1;
        compare_next(valB);
        tick();
        read_dbg(4'h5, 64'd0, "mrmovq_stall_reg5");
        wb_en = 1'b1;
        tick();
        drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1);
        read_dbg(4'h5, 64'd77, "mrmovq_reg5");

        // Unknown icode decodes to no ids
        drive(4'hC, 4'h1, 4'h2, 1'b1, 64'd5, 64'd6, 1'b1);
        expect_ids("unknown", 4'hF, 4'hF, 4'hF, 4'hF);
        tick();
        read_dbg(4'h2, 64'd1234, "unknown_reg2");

        // Load reg1, then PUSHQ, then async reset mid-cycle
        drive(4'h3, 4'hF, 4'h1, 1'b0, 64'd55, 64'd0, 1'b1);
        tick();
        drive(4'hA, 4'h1, 4'hF, 1'b0, 64'h200, 64'd0, 1'b1);
        expect_ids("pushq", 4'h1, 4'h4, 4'h4, 4'hF);
        expect_v("pushq_valA", 64'd55);
        #1;
        compare_next(valA);
        tick();
        read_dbg(4'h4, 64'h200, "pushq_reg4");
        #2 rst = 1'b1;
        #1;
        read_dbg(4'h1, 64'd0, "async_rst_reg1");
        read_dbg(4'h4, RSP_INIT, "async_rst_reg4");
        expect_v("async_rst_valB", RSP_INIT);
        #1;
        compare_next(valB);
        // Edge with rst held high must discard the write
        drive(4'h3, 4'hF, 4'h1, 1'b0, 64'd99, 64'd0, 1'b1);
        tick();
        read_dbg(4'h1, 64'd0, "rst_edge_reg1");
        read_dbg(4'h4, RSP_INIT, "rst_edge_reg4");
        drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1);
        rst = 1'b0;
        tick();
        read_dbg(4'h1, 64'd0, "post_rst_reg1");
        read_dbg(4'h4, RSP_INIT, "post_rst_reg4");

        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish, want finish before 20000");
        $fatal(1);
    end

endmodule
